mdu_sequencer: RTL

- Multi-cycle multiply/divide sequencer beside the E-stage ALU. Executes mult/multu/div/divu/mthi/mtlo on the forwarded E-stage operands and owns the HI/LO registers.
- Drives Busy/Stall so the hazard unit freezes F/D while a result is pending.
- Cancel gates instruction issue when an exception or interrupt flushes the E stage.

---
 rtl/mdu_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO registers.
// Results are computed at accept, held in shadow registers, and committed after the busy window.
module mdu_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] SrcA_E,
  input  logic [31:0] SrcB_E,
  input  logic        Cancel,
  output logic        Busy,
  output logic        Stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [4:0] MultCnt = 5'(MULT_CYCLES);
  localparam logic [4:0] DivCnt  = 5'(DIV_CYCLES);

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;
  logic        commit_q, commit_d;

  logic        accept;
  logic        is_md;
  logic        div_zero;

  logic [63:0] prod_s, prod_u;
  logic [31:0] mag_a, mag_b, den_s, uq_s, ur_s, q_s, r_s;
  logic [31:0] den_u, q_u, r_u;

  assign Busy     = (state_q == StRun);
  assign is_md    = ~MDOp[2];
  assign Stall    = Busy | (Start & ~Cancel & is_md);
  assign accept   = Start & ~Cancel & ~Busy & (state_q == StIdle);
  assign div_zero = (SrcB_E == 32'd0);
  assign HI       = hi_q;
  assign LO       = lo_q;

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign prod_s = {{32{SrcA_E[31]}}, SrcA_E} * {{32{SrcB_E[31]}}, SrcB_E};
  assign prod_u = {32'd0, SrcA_E} * {32'd0, SrcB_E};

  // Signed divide via magnitudes; the divisor is forced non-zero so no X leaks out.
  assign mag_a = SrcA_E[31] ? (32'd0 - SrcA_E) : SrcA_E;
  assign mag_b = SrcB_E[31] ? (32'd0 - SrcB_E) : SrcB_E;
  assign den_s = div_zero ? 32'd1 : mag_b;
  assign uq_s  = mag_a / den_s;
  assign ur_s  = mag_a % den_s;
  assign q_s   = (SrcA_E[31] ^ SrcB_E[31]) ? (32'd0 - uq_s) : uq_s;
  assign r_s   = SrcA_E[31] ? (32'd0 - ur_s) : ur_s;

  assign den_u = div_zero ? 32'd1 : SrcB_E;
  assign q_u   = SrcA_E / den_u;
  assign r_u   = SrcA_E % den_u;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    sh_hi_d  = sh_hi_q;
    sh_lo_d  = sh_lo_q;
    commit_d = commit_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          unique case (MDOp)
            OpMult: begin
              {sh_hi_d, sh_lo_d} = prod_s;
              cnt_d              = MultCnt;
              commit_d           = 1'b1;
              state_d            = StRun;
            end
            OpMultu: begin
              {sh_hi_d, sh_lo_d} = prod_u;
              cnt_d              = MultCnt;
              commit_d           = 1'b1;
              state_d            = StRun;
            end
            OpDiv: begin
              sh_hi_d  = r_s;
              sh_lo_d  = q_s;
              cnt_d    = DivCnt;
              commit_d = ~div_zero;
              state_d  = StRun;
            end
            OpDivu: begin
              sh_hi_d  = r_u;
              sh_lo_d  = q_u;
              cnt_d    = DivCnt;
              commit_d = ~div_zero;
              state_d  = StRun;
            end
            OpMthi:  hi_d = SrcA_E;
            OpMtlo:  lo_d = SrcA_E;
            default: ;
          endcase
        end
      end
      StRun: begin
        cnt_d = cnt_q - 5'd1;
        // Guarding with <= 1 keeps a corrupted zero count from wrapping into a long stall.
        if (cnt_q <= 5'd1) begin
          cnt_d   = 5'd0;
          state_d = StIdle;
          if (commit_q) begin
            hi_d = sh_hi_q;
            lo_d = sh_lo_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= 5'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      sh_hi_q  <= 32'd0;
      sh_lo_q  <= 32'd0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      sh_hi_q  <= sh_hi_d;
      sh_lo_q  <= sh_lo_d;
      commit_q <= commit_d;
    end
  end

endmodule
